sdram_word_bridge: RTL and testbench

- Host-side front end for the 16-bit SDRAM controller.
- Accepts single 32-bit word read/write requests from the system bus and splits each into two 16-bit controller transactions: low half first, then high half.
- Sequences the controller's one-cycle rd_enable/wr_enable pulses against its registered busy flag.
- Detects transactions lost to controller-initiated refresh and re-issues them.
- Returns one completion per host request.

---
 rtl/sdram_word_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_sdram_word_bridge.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_word_bridge.sv
// -----------------------------------------------------------------------------
// sdram_word_bridge
//
// Host-side front end for the 16-bit SDRAM controller. Each 32-bit host word
// request is split into two halfword controller transactions, low half first.
// The bridge sequences the controller's one-cycle rd/wr enable pulses against
// its registered busy flag. It detects a transaction that a controller-initiated
// refresh has swallowed and re-issues it. It returns one ack per host request.
//
// Ports
//   clk, rst_n     : system clock (shared with controller), async active-low reset
//   host_req       : request valid, held with fields stable until host_ack
//   host_we        : 1 = write, 0 = read
//   host_addr      : 32-bit word address (HADDR_WIDTH-1 bits)
//   host_wdata     : write data
//   host_ack       : one-cycle completion pulse
//   host_rdata     : assembled read data, valid while host_ack = 1 for a read
//   sd_wr_addr     : controller write halfword address (registered)
//   sd_wr_data     : controller write data (registered)
//   sd_wr_enable   : controller write pulse
//   sd_rd_addr     : controller read halfword address (registered)
//   sd_rd_enable   : controller read pulse
//   sd_rd_data     : controller read data
//   sd_rd_ready    : controller read data valid
//   sd_busy        : controller busy flag
// -----------------------------------------------------------------------------
module sdram_word_bridge #(
    parameter int HADDR_WIDTH    = 24,
    parameter int REF_BUSY_MIN   = 9,
    parameter int ACCEPT_TIMEOUT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [HADDR_WIDTH-2:0] host_addr,
    input  logic [31:0]            host_wdata,
    output logic                   host_ack,
    output logic [31:0]            host_rdata,
    output logic [HADDR_WIDTH-1:0] sd_wr_addr,
    output logic [15:0]            sd_wr_data,
    output logic                   sd_wr_enable,
    output logic [HADDR_WIDTH-1:0] sd_rd_addr,
    output logic                   sd_rd_enable,
    input  logic [15:0]            sd_rd_data,
    input  logic                   sd_rd_ready,
    input  logic                   sd_busy
);

    localparam int WIN_W = $clog2(REF_BUSY_MIN + 1);
    localparam int TO_W  = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;

    localparam logic [WIN_W-1:0] WIN_SAT = WIN_W'(REF_BUSY_MIN);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACCEPT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   w_half_done;

    logic                   r_we;
    logic [HADDR_WIDTH-2:0] r_addr;
    logic [31:0]            r_wdata;
    logic                   r_half;
    logic                   r_settle_ok;   // previous cycle was SETTLE with busy low
    logic [TO_W-1:0]        r_to_cnt;      // idle cycles seen in WAIT_HI
    logic [WIN_W-1:0]       r_win_cnt;     // busy-high cycles in this window, saturating
    logic                   r_rd_seen;     // rd_ready arrived since the last pulse
    logic [31:0]            r_rdata;
    logic [HADDR_WIDTH-1:0] r_sd_addr;
    logic [15:0]            r_sd_wdata;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and pulse outputs
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        w_next       = r_state;
        w_half_done  = 1'b0;
        sd_wr_enable = 1'b0;
        sd_rd_enable = 1'b0;
        host_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (host_req) w_next = SETTLE;
            end
            SETTLE: begin
                // Two consecutive idle cycles hide the controller's one-cycle
                // busy gap between back-to-back operations.
                if (!sd_busy && r_settle_ok) w_next = ISSUE;
            end
            ISSUE: begin
                sd_wr_enable = r_we;
                sd_rd_enable = !r_we;
                w_next       = WAIT_HI;
            end
            WAIT_HI: begin
                if (sd_busy) begin
                    w_next = WAIT_LO;
                end else if (r_to_cnt == TO_LAST) begin
                    w_next = SETTLE;                   // pulse never taken: re-issue
                end
            end
            WAIT_LO: begin
                if (!sd_busy) begin
                    // A read is good only if its data came back; a write is good
                    // only if the window was too short to be a refresh.
                    if (r_we) w_half_done = (r_win_cnt < WIN_SAT);
                    else      w_half_done = r_rd_seen || sd_rd_ready;
                    if (w_half_done && r_half) w_next = DONE;
                    else                       w_next = SETTLE;
                end
            end
            DONE: begin
                host_ack = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: request latch, counters, controller-facing registers
    // -------------------------------------------------------------------------
    // NOTE: all of these are plain registers, so each is cleared by reset;
    // nothing here is a memory array that would need to be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_half      <= 1'b0;
            r_settle_ok <= 1'b0;
            r_to_cnt    <= '0;
            r_win_cnt   <= '0;
            r_rd_seen   <= 1'b0;
            r_rdata     <= '0;
            r_sd_addr   <= '0;
            r_sd_wdata  <= '0;
        end else begin
            r_settle_ok <= (r_state == SETTLE) && !sd_busy;

            case (r_state)
                IDLE: begin
                    if (host_req) begin
                        r_we    <= host_we;
                        r_addr  <= host_addr;
                        r_wdata <= host_wdata;
                        r_half  <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Load address/data so they are stable from the pulse cycle on.
                    if (w_next == ISSUE) begin
                        r_sd_addr  <= {r_addr, r_half};
                        r_sd_wdata <= r_half ? r_wdata[31:16] : r_wdata[15:0];
                    end
                end
                ISSUE: begin
                    r_win_cnt <= '0;
                    r_to_cnt  <= '0;
                end
                WAIT_HI: begin
                    if (sd_busy) r_win_cnt <= WIN_W'(1);
                    else         r_to_cnt  <= r_to_cnt + 1'b1;
                end
                WAIT_LO: begin
                    if (sd_busy && (r_win_cnt != WIN_SAT)) r_win_cnt <= r_win_cnt + 1'b1;
                    if (w_half_done && !r_half)            r_half    <= 1'b1;
                end
                default: ;
            endcase

            // Read data may arrive in any active state; it always belongs to the
            // half currently being worked on.
            if ((r_state != IDLE) && !r_we && sd_rd_ready) begin
                if (r_half) r_rdata[31:16] <= sd_rd_data;
                else        r_rdata[15:0]  <= sd_rd_data;
            end

            // Any rd_ready seen before a fresh pulse belongs to an older attempt.
            if (r_state == ISSUE)  r_rd_seen <= 1'b0;
            else if (sd_rd_ready)  r_rd_seen <= 1'b1;
        end
    end

    assign sd_wr_addr = r_sd_addr;
    assign sd_rd_addr = r_sd_addr;
    assign sd_wr_data = r_sd_wdata;
    assign host_rdata = r_rdata;

endmodule

// File: tb/tb_sdram_word_bridge.sv
// -----------------------------------------------------------------------------
// tb_sdram_word_bridge
//
// Bench for sdram_word_bridge. It contains a behavioural SDRAM controller with
// registered busy, injectable refresh steals, a long-window injection and a
// "deaf" mode. A word-level reference memory supplies the expected read data
// and the expected halfword transactions for each host request.
// -----------------------------------------------------------------------------
module tb_sdram_word_bridge;

    localparam int HAW = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             host_req;
    logic             host_we;
    logic [HAW-2:0]   host_addr;
    logic [31:0]      host_wdata;
    logic             host_ack;
    logic [31:0]      host_rdata;
    logic [HAW-1:0]   sd_wr_addr;
    logic [15:0]      sd_wr_data;
    logic             sd_wr_enable;
    logic [HAW-1:0]   sd_rd_addr;
    logic             sd_rd_enable;
    logic [15:0]      sd_rd_data;
    logic             sd_rd_ready;
    logic             sd_busy;

    always #5 clk = ~clk;

    sdram_word_bridge #(
        .HADDR_WIDTH    (HAW),
        .REF_BUSY_MIN   (9),
        .ACCEPT_TIMEOUT (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .sd_wr_addr   (sd_wr_addr),
        .sd_wr_data   (sd_wr_data),
        .sd_wr_enable (sd_wr_enable),
        .sd_rd_addr   (sd_rd_addr),
        .sd_rd_enable (sd_rd_enable),
        .sd_rd_data   (sd_rd_data),
        .sd_rd_ready  (sd_rd_ready),
        .sd_busy      (sd_busy)
    );

    // ---------------------------------------------------------------- checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------- controller model
    typedef struct {
        bit             we;
        logic [HAW-1:0] addr;
        logic [15:0]    data;
    } txn_t;

    txn_t           acc_q[$];          // halfword ops the controller actually performed
    logic [15:0]    cmem [0:1023];
    bit   [1023:0]  cvalid;
    int             rem = 0;
    int             attempts = 0;      // pulses taken by a non-busy, non-deaf controller
    int             pulse_while_busy = 0;
    bit             op_rd = 1'b0;
    bit             op_steal = 1'b0;
    logic [HAW-1:0] op_addr = '0;

    // Stimulus-owned knobs
    int cfg_win  = 4;                  // busy window of a normal op
    int steal_at = -1;                 // attempt index turned into an 11-cycle refresh
    int long_at  = -1;                 // attempt index accepted with a 9-cycle window
    bit deaf     = 1'b0;               // ignore every pulse

    function automatic logic [15:0] fill(input logic [HAW-1:0] x);
        logic [HAW-1:0] p;
        p = x * 24'h009E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] mem_rd(input logic [HAW-1:0] x);
        return cvalid[x[9:0]] ? cmem[x[9:0]] : fill(x);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sd_busy     <= 1'b0;
            sd_rd_ready <= 1'b0;
            sd_rd_data  <= '0;
            rem         <= 0;
        end else begin
            sd_rd_ready <= 1'b0;
            if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) sd_busy <= 1'b0;
                if (rem == 2 && op_rd && !op_steal) begin
                    sd_rd_ready <= 1'b1;
                    sd_rd_data  <= mem_rd(op_addr);
                end
                if (sd_wr_enable || sd_rd_enable) pulse_while_busy <= pulse_while_busy + 1;
            end else if ((sd_wr_enable || sd_rd_enable) && !deaf) begin
                attempts <= attempts + 1;
                op_steal <= (attempts == steal_at);
                op_rd    <= sd_rd_enable;
                op_addr  <= sd_rd_enable ? sd_rd_addr : sd_wr_addr;
                sd_busy  <= 1'b1;
                if (attempts == steal_at)     rem <= 11;
                else if (attempts == long_at) rem <= 9;
                else                          rem <= cfg_win;
                if (attempts != steal_at) begin
                    if (sd_wr_enable) begin
                        cmem[sd_wr_addr[9:0]]   <= sd_wr_data;
                        cvalid[sd_wr_addr[9:0]] <= 1'b1;
                        acc_q.push_back('{1'b1, sd_wr_addr, sd_wr_data});
                    end else begin
                        acc_q.push_back('{1'b0, sd_rd_addr, mem_rd(sd_rd_addr)});
                        if (cfg_win == 1 && attempts != long_at) begin
                            sd_rd_ready <= 1'b1;
                            sd_rd_data  <= mem_rd(sd_rd_addr);
                        end
                    end
                end
            end
        end
    end

    // ----------------------------------------------------------------- monitor
    int cyc = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int both_high = 0;
    int ack_cnt = 0;
    int pulse_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sd_wr_enable) wr_pulses <= wr_pulses + 1;
        if (sd_rd_enable) rd_pulses <= rd_pulses + 1;
        if (sd_wr_enable && sd_rd_enable) both_high <= both_high + 1;
        if (sd_wr_enable || sd_rd_enable) pulse_cyc_q.push_back(cyc);
        if (host_ack) ack_cnt <= ack_cnt + 1;
    end

    // --------------------------------------------------------- reference model
    logic [31:0] ref_mem [logic [HAW-2:0]];
    int          last_lat = 0;

    function automatic logic [31:0] ref_read(input logic [HAW-2:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {fill({a, 1'b1}), fill({a, 1'b0})};
    endfunction

    task automatic start_req(input bit we, input logic [HAW-2:0] a, input logic [31:0] wd);
        @(negedge clk);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = a;
        host_wdata = wd;
    endtask

    task automatic wait_ack(input string tag, output logic [31:0] rd, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge clk);
            if (host_ack) begin
                seen     = 1'b1;
                lat      = i;
                rd       = host_rdata;
                host_req = 1'b0;
            end
        end
        host_req = 1'b0;
        check({tag, "_ack_seen"}, seen, 1);
    endtask

    // xp: extra pulses expected, xa: extra accepted controller ops expected
    task automatic do_req(input string tag, input bit we, input logic [HAW-2:0] a,
                          input logic [31:0] wd, input int xp, input int xa);
        int          acc0, wr0, rd0, ack0, lat;
        logic [31:0] exp_rd, got_rd;
        txn_t        lo, hi;
        acc0   = acc_q.size();
        wr0    = wr_pulses;
        rd0    = rd_pulses;
        ack0   = ack_cnt;
        exp_rd = ref_read(a);
        start_req(we, a, wd);
        wait_ack(tag, got_rd, lat);
        @(negedge clk);
        last_lat = lat;
        check({tag, "_acks"}, ack_cnt - ack0, 1);
        check({tag, "_pulses"}, we ? (wr_pulses - wr0) : (rd_pulses - rd0), 2 + xp);
        check({tag, "_other_pulses"}, we ? (rd_pulses - rd0) : (wr_pulses - wr0), 0);
        check({tag, "_accepted"}, acc_q.size() - acc0, 2 + xa);
        if (acc_q.size() >= acc0 + 2) begin
            lo = acc_q[acc_q.size() - 2];
            hi = acc_q[acc_q.size() - 1];
            check({tag, "_lo_addr"}, lo.addr, {a, 1'b0});
            check({tag, "_hi_addr"}, hi.addr, {a, 1'b1});
            check({tag, "_lo_kind"}, lo.we, we);
            check({tag, "_hi_kind"}, hi.we, we);
            if (we) begin
                check({tag, "_lo_data"}, lo.data, wd[15:0]);
                check({tag, "_hi_data"}, hi.data, wd[31:16]);
            end
        end
        if (we) ref_mem[a] = wd;
        else    check({tag, "_rdata"}, got_rd, exp_rd);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // --------------------------------------------------------------- stimulus
    initial begin
        int          base, ack0, wr0, lat, npulse;
        bit          seen, rnd_we, rnd_st;
        logic [HAW-2:0] rnd_addr;
        logic [31:0] rnd_data, got_rd;

        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;

        // Reset state
        #12;
        check("rst_wr_en",   sd_wr_enable, 0);
        check("rst_rd_en",   sd_rd_enable, 0);
        check("rst_ack",     host_ack, 0);
        check("rst_wr_addr", sd_wr_addr, 0);
        check("rst_rd_addr", sd_rd_addr, 0);
        check("rst_wr_data", sd_wr_data, 0);
        check("rst_rdata",   host_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic write then read, with minimum read latency 2*(2+1+W+1)+1
        cfg_win = 4;
        do_req("wr_beef", 1'b1, 23'h12, 32'hDEADBEEF, 0, 0);
        do_req("rd_beef", 1'b0, 23'h12, 32'h0, 0, 0);
        check("rd_latency", last_lat, 17);

        // Refresh swallows the first write pulse
        cfg_win  = 5;
        steal_at = attempts;
        do_req("wr_steal_lo", 1'b1, 23'h31, 32'h12345678, 1, 0);
        steal_at = -1;
        do_req("rd_31", 1'b0, 23'h31, 32'h0, 0, 0);

        // Refresh swallows the high-half read
        steal_at = attempts + 1;
        do_req("rd_steal_hi", 1'b0, 23'h12, 32'h0, 1, 0);
        steal_at = -1;

        // Window length boundary: 8 busy cycles is an op, 9 is a refresh
        cfg_win = 8;
        do_req("wr_win8", 1'b1, 23'h40, 32'hA5A50F0F, 0, 0);
        long_at = attempts;
        do_req("wr_win9", 1'b1, 23'h41, 32'h13579BDF, 1, 1);
        long_at = -1;
        cfg_win = 3;
        do_req("rd_40", 1'b0, 23'h40, 32'h0, 0, 0);
        do_req("rd_41", 1'b0, 23'h41, 32'h0, 0, 0);

        // Controller never answers: pulse repeats every 2+1+3 cycles, no ack
        deaf = 1'b1;
        base = pulse_cyc_q.size();
        ack0 = ack_cnt;
        start_req(1'b1, 23'h55, 32'h0F1E2D3C);
        repeat (40) @(negedge clk);
        npulse = pulse_cyc_q.size() - base;
        check("deaf_pulse_count_ge4", npulse >= 4, 1);
        if (npulse >= 4) begin
            for (int i = 1; i < 4; i++)
                check("deaf_period", pulse_cyc_q[base + i] - pulse_cyc_q[base + i - 1], 6);
        end
        check("deaf_no_ack", ack_cnt - ack0, 0);
        deaf = 1'b0;
        wait_ack("deaf_recover", got_rd, lat);
        @(negedge clk);
        check("deaf_recover_acks", ack_cnt - ack0, 1);
        ref_mem[23'h55] = 32'h0F1E2D3C;
        do_req("rd_55", 1'b0, 23'h55, 32'h0, 0, 0);

        // Asynchronous reset in the middle of the high half's busy window
        cfg_win = 8;
        wr0  = wr_pulses;
        ack0 = ack_cnt;
        start_req(1'b1, 23'h77, 32'hCAFEF00D);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (wr_pulses >= wr0 + 2) seen = 1'b1;
        end
        check("rst_mid_hi_issued", seen, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en",   sd_wr_enable, 0);
        check("rst_mid_rd_en",   sd_rd_enable, 0);
        check("rst_mid_ack",     host_ack, 0);
        check("rst_mid_wr_addr", sd_wr_addr, 0);
        check("rst_mid_rd_addr", sd_rd_addr, 0);
        check("rst_mid_wr_data", sd_wr_data, 0);
        check("rst_mid_rdata",   host_rdata, 0);
        host_req = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_no_ack", ack_cnt - ack0, 0);
        cfg_win = 4;
        do_req("post_rst_wr", 1'b1, 23'h77, 32'h0BADCAFE, 0, 0);
        do_req("post_rst_rd", 1'b0, 23'h77, 32'h0, 0, 0);

        // Randomized mix with random windows and refresh steals
        for (int n = 0; n < 40; n++) begin
            rnd_we   = 1'($urandom_range(0, 1));
            rnd_addr = 23'(12'h100 + $urandom_range(0, 7));
            rnd_data = $urandom;
            rnd_st   = ($urandom_range(0, 2) == 0);
            cfg_win  = rnd_we ? int'($urandom_range(1, 8)) : int'($urandom_range(1, 12));
            steal_at = rnd_st ? attempts + int'($urandom_range(0, 1)) : -1;
            do_req("rand", rnd_we, rnd_addr, rnd_data, rnd_st ? 1 : 0, 0);
        end
        steal_at = -1;

        check("both_enables_high", both_high, 0);
        check("pulse_while_busy", pulse_while_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
